key_poll_master: RTL and testbench
==================================

Name: key_poll_master

Overview:
- Avalon-MM read initiator that periodically polls a 2-bit key input PIO slave (32-bit readdata, data at address 0, registered readdata, no waitrequest, fixed read latency 1).
- Converts raw samples into debounced key state, one-cycle press/release pulses and sticky per-key event flags for game-control logic (Tetris move/rotate).
- Lets hardware consume key events without a CPU in the loop.

Parameters:
- WIDTH, 2, number of keys polled (readdata[WIDTH-1:0]).
- POLL_DIV, 50000, IDLE cycles between polls (1 ms at 50 MHz); legal range >= 1.
- READ_LATENCY, 1, cycles from read issue to valid readdata; legal range >= 1.
- STABLE_SAMPLES, 4, consecutive differing polls needed to accept a change; legal range >= 1.
- ACTIVE_LOW, 1, 1 = raw bit 0 means pressed (input inverted before debounce).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable.
- avm_address  out  2  slave word address; constant 0.
- avm_read  out  1  read strobe, one cycle per poll.
- avm_readdata  in  32  slave read data; bits above WIDTH-1 ignored.
- keys_db  out  WIDTH  debounced key state, 1 = pressed.
- key_press  out  WIDTH  one-cycle pulse on debounced 0->1.
- key_release  out  WIDTH  one-cycle pulse on debounced 1->0.
- event_pending  out  WIDTH  sticky press flag per key.
- event_ack  in  WIDTH  per-key clear of event_pending.

Behaviour:
- Clock and reset: clk; reset_n is asynchronous, active-low.
- Reset values:
  - state IDLE, interval counter 0, per-bit stability counters 0, sample register 0.
  - avm_address 0, avm_read 0.
  - keys_db 0, key_press 0, key_release 0, event_pending 0.
- FSM states: IDLE, REQ, WAIT, CAPTURE.
  - IDLE: counter runs only while enable=1. At count POLL_DIV-1, clear the counter and go to REQ. While enable=0, hold the counter at 0.
  - REQ: avm_read=1 for exactly this cycle. Always go to WAIT.
  - WAIT: lasts READ_LATENCY cycles. On the last WAIT cycle, latch avm_readdata[WIDTH-1:0] XOR {WIDTH{ACTIVE_LOW}} into the sample register. Then go to CAPTURE.
  - CAPTURE: debounce update (below). Then go to IDLE.
- Poll period: POLL_DIV+READ_LATENCY+2 cycles while enabled.
- Deasserting enable mid-transaction: REQ/WAIT/CAPTURE complete normally; the FSM then parks in IDLE.
- avm_read is 0 in every state except REQ. avm_address is always 0.
- Debounce, per bit i, evaluated in CAPTURE:
  - sample[i]==keys_db[i]: clear cnt[i].
  - sample[i]!=keys_db[i] and cnt[i]==STABLE_SAMPLES-1: toggle keys_db[i], clear cnt[i], pulse key_press[i] or key_release[i].
  - Otherwise: increment cnt[i].
  - A change is accepted on the STABLE_SAMPLES-th consecutive differing poll. Any matching poll restarts the count.
  - STABLE_SAMPLES=1 means no filtering.
  - Counter width: clog2(STABLE_SAMPLES), minimum 1.
- Pulses: key_press/key_release are registered and high for exactly the one cycle after CAPTURE, i.e. the cycle in which the new keys_db first appears.
- event_pending[i]:
  - Set when key_press[i] asserts.
  - Cleared by event_ack[i]=1.
  - Set and ack in the same cycle: set wins.
- Multiple keys changing in one poll produce simultaneous pulses.
- Reset mid-operation returns immediately to reset values; no partial read is tracked.

Decomposition:
- Package key_poll_pkg: FSM state enum (IDLE, REQ, WAIT, CAPTURE); localparam KEY_PIO_DATA_ADDR=2'd0.
- Sub-module key_debounce_bit, instantiated WIDTH times by generate.
  - Inputs: clk, reset_n, update strobe, sample bit.
  - Outputs: db, press, release.
- FSM and Avalon-MM signalling stay in the top.

Test Plan:
All cases use POLL_DIV=4, READ_LATENCY=1, STABLE_SAMPLES=3, ACTIVE_LOW=1, and a behavioural latency-1 PIO slave model.
- Reset/idle: reset_n low, enable=1, readdata=32'h3 -> avm_read pulses every 7 cycles; keys_db stays 2'b00; no pulses; avm_address always 0.
- Press accept: bit0 low from cycle 0 -> key_press=2'b01 for exactly one cycle, one cycle after the 3rd poll's CAPTURE; keys_db=2'b01; event_pending=2'b01.
- Bounce reject: bit1 low for 2 polls, high for 1, low for 2 -> no change. Bit1 held low for 3 consecutive polls -> key_press=2'b10 once.
- Release and ack: with keys_db=2'b01, bit0 returns high for 3 polls -> key_release=2'b01 once. event_ack=2'b01 -> event_pending=0 next cycle. Ack in the same cycle as a new press -> event_pending stays 1.
- Enable/garbage bits: enable dropped during WAIT -> CAPTURE completes, then no further reads until enable=1. readdata=32'hFFFF_FFFC -> both keys pressed after 3 polls; upper bits ignored.
- Async reset mid-WAIT with keys_db=2'b11 -> all outputs 0 immediately; first post-reset read after 4 IDLE cycles.

Source files
------------

// File: rtl/key_poll_pkg.sv
`default_nettype none
// ============================================================================
// Module  : key_poll_pkg
// Purpose : Shared types and constants for the key polling master: the poll
//           FSM state encoding and the word address of the key PIO data
//           register.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package key_poll_pkg;

  // Poll sequencer states; 2-bit encoding covers all four exactly.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } poll_state_t;

  // Word address of the key PIO data register.
  localparam logic [1:0] KEY_PIO_DATA_ADDR = 2'd0;

endpackage : key_poll_pkg
`default_nettype wire

// File: rtl/key_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_bit
// Purpose : Single-key debouncer driven by a poll strobe. A new level is
//           accepted only after STABLE_SAMPLES consecutive polls that differ
//           from the current debounced state; any agreeing poll restarts the
//           count. Emits one-cycle press/release pulses aligned with the
//           first cycle the new debounced level is visible.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           update  - one-cycle strobe, evaluate 'sample' this cycle
//           sample  - polled key level, 1 = pressed
//           db      - debounced key level, 1 = pressed
//           press   - one-cycle pulse on debounced 0->1
//           rel     - one-cycle pulse on debounced 1->0
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce_bit #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic update,
  input  logic sample,
  output logic db,
  output logic press,
  output logic rel
);

  localparam int              CNT_W    = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      db    <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      // Pulses live for a single cycle unless re-armed below.
      press <= 1'b0;
      rel   <= 1'b0;
      if (update) begin
        if (sample == db) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // This is the STABLE_SAMPLES-th consecutive differing poll.
          db    <= ~db;
          cnt   <= '0;
          press <= ~db;
          rel   <= db;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule : key_debounce_bit
`default_nettype wire

// File: rtl/key_poll_master.sv
`default_nettype none
// ============================================================================
// Module  : key_poll_master
// Purpose : Avalon-MM read initiator that periodically polls a key PIO slave
//           (fixed read latency, no waitrequest), debounces each key and
//           exposes debounced state, press/release pulses and sticky
//           per-key press flags so hardware can consume key events directly.
// Ports   : clk           - system clock
//           reset_n       - asynchronous active-low reset
//           enable        - polling enable (in-flight poll always completes)
//           avm_address   - slave word address, always the data register
//           avm_read      - read strobe, one cycle per poll
//           avm_readdata  - slave read data, bits above WIDTH-1 ignored
//           keys_db       - debounced key state, 1 = pressed
//           key_press     - one-cycle pulse per key on debounced 0->1
//           key_release   - one-cycle pulse per key on debounced 1->0
//           event_pending - sticky per-key press flag
//           event_ack     - per-key clear of event_pending (press wins)
// Revision: 1.0 - initial release
// ============================================================================
module key_poll_master
  import key_poll_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int POLL_DIV       = 50000,
  parameter int READ_LATENCY   = 1,
  parameter int STABLE_SAMPLES = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] keys_db,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] event_pending,
  input  logic [WIDTH-1:0] event_ack
);

  localparam int               DIV_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int               LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic             INVERT   = (ACTIVE_LOW != 0);

  poll_state_t      state, state_next;
  logic [DIV_W-1:0] idle_cnt, idle_cnt_next;
  logic [LAT_W-1:0] wait_cnt, wait_cnt_next;
  logic             load_sample;
  logic [WIDTH-1:0] sample;
  logic             update;

  // Only the low WIDTH bits carry key levels; the rest is folded here so the
  // whole bus is visibly consumed.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;

  // --------------------------------------------------------------------------
  // Poll sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idle_cnt <= '0;
      wait_cnt <= '0;
      sample   <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      wait_cnt <= wait_cnt_next;
      if (load_sample) begin
        // Normalise to 1 = pressed before debouncing.
        sample <= avm_readdata[WIDTH-1:0] ^ {WIDTH{INVERT}};
      end
    end
  end

  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    wait_cnt_next = wait_cnt;
    load_sample   = 1'b0;
    unique case (state)
      IDLE: begin
        // Counter only advances while enabled; disabling parks it at zero.
        if (enable) begin
          if (idle_cnt == DIV_LAST) begin
            idle_cnt_next = '0;
            state_next    = REQ;
          end else begin
            idle_cnt_next = idle_cnt + DIV_W'(1);
          end
        end else begin
          idle_cnt_next = '0;
        end
      end
      REQ: begin
        state_next = WAIT;
      end
      WAIT: begin
        // readdata is valid on the last WAIT cycle.
        if (wait_cnt == LAT_LAST) begin
          wait_cnt_next = '0;
          load_sample   = 1'b1;
          state_next    = CAPTURE;
        end else begin
          wait_cnt_next = wait_cnt + LAT_W'(1);
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign avm_read    = (state == REQ);
  assign avm_address = KEY_PIO_DATA_ADDR;
  assign update      = (state == CAPTURE);

  // --------------------------------------------------------------------------
  // Per-key debounce
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce_bit #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .update  (update),
      .sample  (sample[i]),
      .db      (keys_db[i]),
      .press   (key_press[i]),
      .rel     (key_release[i])
    );
  end

  // --------------------------------------------------------------------------
  // Sticky press flags: a press arriving with an ack keeps the flag set.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_pending <= '0;
    end else begin
      event_pending <= (event_pending & ~event_ack) | key_press;
    end
  end

endmodule : key_poll_master
`default_nettype wire

// File: tb/tb_key_poll_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_poll_master
// Purpose : Directed self-checking bench for key_poll_master with a
//           behavioural latency-1 key PIO slave. POLL_DIV=4, READ_LATENCY=1,
//           STABLE_SAMPLES=3, ACTIVE_LOW=1 (poll period 7 cycles).
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_poll_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic [1:0]  keys_db;
  logic [1:0]  key_press;
  logic [1:0]  key_release;
  logic [1:0]  event_pending;
  logic [1:0]  event_ack;

  logic [31:0] raw;      // level presented by the PIO slave
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Registered readdata, valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (avm_read) avm_readdata <= raw;
  end

  key_poll_master #(
    .WIDTH          (2),
    .POLL_DIV       (4),
    .READ_LATENCY   (1),
    .STABLE_SAMPLES (3),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .avm_address   (avm_address),
    .avm_read      (avm_read),
    .avm_readdata  (avm_readdata),
    .keys_db       (keys_db),
    .key_press     (key_press),
    .key_release   (key_release),
    .event_pending (event_pending),
    .event_ack     (event_ack)
  );

  // Advance to the negedge inside the next REQ cycle (bounded).
  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avm_read !== 1'b1 && n < 40);
    checks++;
    if (avm_read !== 1'b1) begin
      errors++;
      $display("FAIL wait_req: avm_read=%b after %0d cycles, required 1", avm_read, n);
    end
  endtask

  // One full poll: returns values in the pulse cycle (REQ+3) and the cycle
  // after it. ack_at_pulse is driven during the pulse cycle.
  task automatic poll_once(input logic [1:0] ack_at_pulse,
                           output logic [1:0] press, output logic [1:0] rel,
                           output logic [1:0] db, output logic [1:0] press_after,
                           output logic [1:0] pend_after);
    wait_req();
    repeat (3) @(negedge clk);
    press = key_press;
    rel   = key_release;
    db    = keys_db;
    event_ack = ack_at_pulse;
    @(negedge clk);
    event_ack   = 2'b00;
    press_after = key_press;
    pend_after  = event_pending;
  endtask

  task automatic test_reset();
    int n;
    raw       = 32'h3;
    enable    = 1'b1;
    event_ack = 2'b00;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({avm_read, avm_address, keys_db, key_press, key_release, event_pending} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all 0",
               {avm_read, avm_address, keys_db, key_press, key_release, event_pending});
    end
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avm_read !== 1'b1 && n < 20);
    checks++;
    if (n != 4 || avm_read !== 1'b1) begin
      errors++;
      $display("FAIL first_read_latency: got %0d cycles, required 4", n);
    end
    // Interval to the next read, watching outputs on every cycle.
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if (avm_address !== 2'b00 || keys_db !== 2'b00 || key_press !== 2'b00 || key_release !== 2'b00) begin
        errors++;
        $display("FAIL idle_outputs: addr=%b db=%b press=%b rel=%b, required 0",
                 avm_address, keys_db, key_press, key_release);
      end
    end while (avm_read !== 1'b1 && n < 20);
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL poll_period: got %0d cycles, required 7", n);
    end
    repeat (3) @(negedge clk);  // let the in-flight poll finish
  endtask

  task automatic test_press();
    logic [1:0] p, r, d, pa, pe;
    raw = 32'h2;  // bit0 low = key0 pressed
    for (int k = 1; k <= 3; k++) begin
      poll_once(2'b00, p, r, d, pa, pe);
      checks++;
      if (k < 3 && (p !== 2'b00 || d !== 2'b00)) begin
        errors++;
        $display("FAIL press_early poll%0d: press=%b db=%b, required 00 00", k, p, d);
      end
      if (k == 3 && (p !== 2'b01 || d !== 2'b01 || r !== 2'b00 || pa !== 2'b00 || pe !== 2'b01)) begin
        errors++;
        $display("FAIL press_accept: press=%b db=%b rel=%b press_next=%b pend=%b, required 01 01 00 00 01",
                 p, d, r, pa, pe);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0]  p, r, d, pa, pe;
    logic [31:0] seq [6] = '{32'h0, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 6; k++) begin
      raw = seq[k];
      poll_once(2'b00, p, r, d, pa, pe);
      checks++;
      if (k < 5 && (p !== 2'b00 || d !== 2'b01)) begin
        errors++;
        $display("FAIL bounce_reject poll%0d: press=%b db=%b, required 00 01", k, p, d);
      end
      if (k == 5 && (p !== 2'b10 || d !== 2'b11 || pa !== 2'b00 || pe !== 2'b11)) begin
        errors++;
        $display("FAIL bounce_accept: press=%b db=%b press_next=%b pend=%b, required 10 11 00 11",
                 p, d, pa, pe);
      end
    end
  endtask

  task automatic test_release_ack();
    logic [1:0] p, r, d, pa, pe;
    raw = 32'h1;  // key0 released, key1 still pressed
    for (int k = 1; k <= 3; k++) begin
      poll_once(2'b00, p, r, d, pa, pe);
      checks++;
      if (k < 3 && (r !== 2'b00 || d !== 2'b11)) begin
        errors++;
        $display("FAIL release_early poll%0d: rel=%b db=%b, required 00 11", k, r, d);
      end
      if (k == 3 && (r !== 2'b01 || d !== 2'b10 || p !== 2'b00 || pe !== 2'b11)) begin
        errors++;
        $display("FAIL release_accept: rel=%b db=%b press=%b pend=%b, required 01 10 00 11", r, d, p, pe);
      end
    end
    event_ack = 2'b01;
    @(negedge clk);
    event_ack = 2'b00;
    checks++;
    if (event_pending !== 2'b10) begin
      errors++;
      $display("FAIL ack_clear: pending=%b, required 10", event_pending);
    end
    raw = 32'h0;  // key0 pressed again, ack lands on the press pulse
    for (int k = 1; k <= 3; k++) begin
      poll_once((k == 3) ? 2'b01 : 2'b00, p, r, d, pa, pe);
    end
    checks++;
    if (p !== 2'b01 || pe !== 2'b11) begin
      errors++;
      $display("FAIL ack_vs_press: press=%b pending=%b, required 01 11", p, pe);
    end
    event_ack = 2'b11;
    @(negedge clk);
    event_ack = 2'b00;
    checks++;
    if (event_pending !== 2'b00) begin
      errors++;
      $display("FAIL ack_both: pending=%b, required 00", event_pending);
    end
    raw = 32'h3;  // both released in the same poll
    for (int k = 1; k <= 3; k++) begin
      poll_once(2'b00, p, r, d, pa, pe);
    end
    checks++;
    if (r !== 2'b11 || d !== 2'b00 || p !== 2'b00 || pe !== 2'b00) begin
      errors++;
      $display("FAIL release_both: rel=%b db=%b press=%b pend=%b, required 11 00 00 00", r, d, p, pe);
    end
  endtask

  task automatic test_enable_garbage();
    logic [1:0] p, r, d, pa, pe;
    int n;
    raw = 32'hFFFF_FFFC;  // both keys pressed, upper bits set
    wait_req();
    @(negedge clk);       // WAIT
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (keys_db !== 2'b00 || key_press !== 2'b00) begin
      errors++;
      $display("FAIL disable_capture: db=%b press=%b, required 00 00", keys_db, key_press);
    end
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (avm_read === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL disabled_reads: got %0d reads, required 0", n);
    end
    enable = 1'b1;
    // The disabled-window poll counted as the first of three.
    poll_once(2'b00, p, r, d, pa, pe);
    checks++;
    if (p !== 2'b00 || d !== 2'b00) begin
      errors++;
      $display("FAIL garbage_poll2: press=%b db=%b, required 00 00", p, d);
    end
    poll_once(2'b00, p, r, d, pa, pe);
    checks++;
    if (p !== 2'b11 || d !== 2'b11 || pe !== 2'b11) begin
      errors++;
      $display("FAIL garbage_accept: press=%b db=%b pend=%b, required 11 11 11", p, d, pe);
    end
  endtask

  task automatic test_async_reset();
    int n;
    wait_req();
    @(negedge clk);       // WAIT
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read, keys_db, key_press, key_release, event_pending} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: got %b, required all 0",
               {avm_read, keys_db, key_press, key_release, event_pending});
    end
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avm_read !== 1'b1 && n < 20);
    checks++;
    if (n != 4 || avm_read !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read: got %0d cycles, required 4", n);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release_ack();
    test_enable_garbage();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_poll_master
`default_nettype wire
